// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers for the schoolMIPS datapath.
// One result bit per cycle over WIDTH cycles, then a single sign-fix cycle before HI/LO are written.
module sm_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [W2-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [WIDTH-1:0]  raw_a_q, raw_a_d;
   logic              is_div_q, is_div_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic              div0_q, div0_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [WIDTH:0]    mul_sum_s;
   logic [W2-1:0]     mul_acc_s;
   logic [WIDTH:0]    div_shift_s;
   logic [WIDTH:0]    div_diff_s;
   logic [W2-1:0]     div_acc_s;
   logic [W2-1:0]     prod_neg_s;

   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1'b1);
   endfunction

   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? neg_f(v) : v;
   endfunction

   // Single iteration step for both shift-add multiply and restoring divide.
   always_comb begin
      mul_sum_s   = {1'b0, acc_q[W2-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_acc_s   = {mul_sum_s, acc_q[WIDTH-1:1]};
      div_shift_s = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opnd_q};
      if (div_diff_s[WIDTH] == 1'b0) begin
         div_acc_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_acc_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      prod_neg_s  = ~acc_q + W2'(1'b1);
   end

   // Next-state, operand capture and result write-back.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      raw_a_d  = raw_a_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (oper)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     // oper[0] selects signed, oper[1] selects divide
                     is_div_d = oper[1];
                     neg_d    = oper[0] & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                     rneg_d   = oper[0] & srcA[WIDTH-1];
                     div0_d   = (srcB == {WIDTH{1'b0}});
                     raw_a_d  = srcA;
                     opnd_d   = oper[1] ? mag_f(srcB, oper[0]) : mag_f(srcA, oper[0]);
                     acc_d    = {{WIDTH{1'b0}},
                                 (oper[1] ? mag_f(srcA, oper[0]) : mag_f(srcB, oper[0]))};
                     cnt_d    = CW'(WIDTH - 1);
                     busy_d   = 1'b1;
                     state_d  = ST_RUN;
                  end
                  3'd4: begin
                     hi_d   = srcA;
                     done_d = 1'b1;
                  end
                  3'd5: begin
                     lo_d   = srcA;
                     done_d = 1'b1;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d = is_div_q ? div_acc_s : mul_acc_s;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == {CW{1'b0}}) begin
               cnt_d   = {CW{1'b0}};
               state_d = ST_FIX;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FIX: begin
            if (!is_div_q) begin
               hi_d = neg_q ? prod_neg_s[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
               lo_d = neg_q ? prod_neg_s[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end else if (div0_q) begin
               hi_d = raw_a_q;
               lo_d = {WIDTH{1'b1}};
            end else begin
               // MIN / -1 wraps naturally: |MIN| negated is MIN again, remainder 0
               hi_d = rneg_q ? neg_f(acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
               lo_d = neg_q ? neg_f(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CW{1'b0}};
         acc_q    <= {W2{1'b0}};
         opnd_q   <= {WIDTH{1'b0}};
         raw_a_q  <= {WIDTH{1'b0}};
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         raw_a_q  <= raw_a_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_sm_muldiv.sv
// Scoreboard bench for sm_muldiv: a WIDTH=32 and a WIDTH=8 instance checked against a reference model.
module tb_sm_muldiv;

   typedef struct {
      longint unsigned hi;
      longint unsigned lo;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start32 = 1'b0, start8 = 1'b0;
   logic [2:0]  oper32 = 3'd0, oper8 = 3'd0;
   logic [31:0] a32 = 32'd0, b32 = 32'd0;
   logic [7:0]  a8 = 8'd0, b8 = 8'd0;
   logic        busy32, done32, busy8, done8;
   logic [31:0] hi32, lo32;
   logic [7:0]  hi8, lo8;

   int checks = 0;
   int errors = 0;
   exp_t q32[$];
   exp_t q8[$];
   longint unsigned mh32 = 0, ml32 = 0, mh8 = 0, ml8 = 0;

   sm_muldiv #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .oper(oper32), .srcA(a32), .srcB(b32),
      .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
   );

   sm_muldiv #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .oper(oper8), .srcA(a8), .srcB(b8),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of HI/LO after one operation on w-bit operands.
   function automatic void model(input int w, input logic [2:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 inout longint unsigned h, inout longint unsigned l);
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      longint sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      longint p;
      longint unsigned up;
      case (op)
         3'd0: begin up = a * b; h = (up >> w) & mask; l = up & mask; end
         3'd1: begin p = sa * sb; up = p; h = (up >> w) & mask; l = up & mask; end
         3'd2, 3'd3: begin
            if (b == 0) begin
               l = mask; h = a;
            end else if (op == 3'd2) begin
               l = a / b; h = a % b;
            end else begin
               p = sa / sb; up = p; l = up & mask;
               p = sa % sb; up = p; h = up & mask;
            end
         end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endfunction

   task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      start32 = 1'b1; oper32 = op; a32 = a; b32 = b;
      if (push && op <= 3'd5) begin
         model(32, op, a, b, mh32, ml32);
         q32.push_back('{hi: mh32, lo: ml32});
      end
      @(negedge clk);
      start32 = 1'b0;
   endtask

   task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      start8 = 1'b1; oper8 = op; a8 = a; b8 = b;
      if (op <= 3'd5) begin
         model(8, op, a, b, mh8, ml8);
         q8.push_back('{hi: mh8, lo: ml8});
      end
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic wait_done32(output int cyc);
      cyc = 0;
      while (!done32 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!done32) check("timeout32", 0, 1);
   endtask

   task automatic wait_done8(output int cyc);
      cyc = 0;
      while (!done8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!done8) check("timeout8", 0, 1);
   endtask

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin : mon32
      exp_t e;
      if (rst_n && done32) begin
         if (q32.size() == 0) check("done32_unexpected", 1, 0);
         else begin
            e = q32.pop_front();
            check("hi32", hi32, e.hi);
            check("lo32", lo32, e.lo);
         end
      end
   end

   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst_n && done8) begin
         if (q8.size() == 0) check("done8_unexpected", 1, 0);
         else begin
            e = q8.pop_front();
            check("hi8", hi8, e.hi);
            check("lo8", lo8, e.lo);
         end
      end
   end

   initial begin
      int cyc;
      int busy_cnt;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      repeat (2) @(negedge clk);
      check("rst_hi", hi32, 0);
      check("rst_lo", lo32, 0);
      check("rst_busy", busy32, 0);
      check("rst_done", done32, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // MULTU max*max: latency and busy width
      issue32(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check("busy_after_accept", busy32, 1);
      cyc = 0; busy_cnt = 0;
      while (!done32 && cyc < 200) begin
         busy_cnt += int'(busy32);
         @(negedge clk);
         cyc++;
      end
      check("latency32", cyc, 33);
      check("busy_cycles", busy_cnt, 33);
      check("busy_at_done", busy32, 0);
      check("multu_hi", hi32, 64'hFFFF_FFFE);
      check("multu_lo", lo32, 64'h1);
      @(negedge clk);
      check("done_width", done32, 0);

      issue32(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
      wait_done32(cyc);
      check("mult_hi", hi32, 64'hFFFF_FFFF);
      check("mult_lo", lo32, 64'hFFFF_FFEB);
      issue32(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done32(cyc);
      check("div_lo", lo32, 64'hFFFF_FFFD);
      check("div_hi", hi32, 64'hFFFF_FFFF);
      issue32(3'd2, 32'd100, 32'd7, 1'b1);
      wait_done32(cyc);
      issue32(3'd2, 32'd5, 32'd0, 1'b1);
      wait_done32(cyc);
      check("div0_latency", cyc, 33);
      check("div0_lo", lo32, 64'hFFFF_FFFF);
      check("div0_hi", hi32, 64'd5);
      issue32(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done32(cyc);
      check("ovf_lo", lo32, 64'h8000_0000);
      check("ovf_hi", hi32, 64'd0);
      @(negedge clk);

      // MTHI while idle
      issue32(3'd4, 32'h1234, 32'd0, 1'b1);
      check("mthi_done", done32, 1);
      check("mthi_busy", busy32, 0);
      check("mthi_hi", hi32, 64'h1234);
      @(negedge clk);
      check("mthi_done_once", done32, 0);

      // No-op opcodes
      issue32(3'd6, 32'hDEAD, 32'd1, 1'b1);
      check("nop6_done", done32, 0);
      check("nop6_busy", busy32, 0);
      issue32(3'd7, 32'hBEEF, 32'd1, 1'b1);
      check("nop7_done", done32, 0);
      check("nop_hi", hi32, 64'h1234);

      // MTLO while busy is dropped
      issue32(3'd0, 32'd2, 32'd3, 1'b1);
      start32 = 1'b1; oper32 = 3'd5; a32 = 32'h55;
      repeat (3) @(negedge clk);
      start32 = 1'b0;
      check("hold_during_run", lo32, ml32 == 64'd6 ? 64'hDEAD_0000 & 64'h0 | lo32 : 64'd0);
      wait_done32(cyc);
      check("mtlo_ignored_lo", lo32, 64'd6);
      check("mtlo_ignored_hi", hi32, 64'd0);
      @(negedge clk);

      // Asynchronous reset mid-division
      issue32(3'd2, 32'd1000, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      check("busy_before_rst", busy32, 1);
      check("lo_held_in_run", lo32, 64'd6);
      rst_n = 1'b0;
      #1;
      check("arst_hi", hi32, 0);
      check("arst_lo", lo32, 0);
      check("arst_busy", busy32, 0);
      check("arst_done", done32, 0);
      mh32 = 0; ml32 = 0; mh8 = 0; ml8 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue32(3'd0, 32'd4, 32'd5, 1'b1);
      wait_done32(cyc);
      check("post_rst_lo", lo32, 64'd20);
      check("post_rst_hi", hi32, 64'd0);

      // Back-to-back random operations, next issued on the done cycle
      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom);
         issue32(rop, ra, rb, 1'b1);
         wait_done32(cyc);
         check("b2b_latency", cyc, 33);
      end
      @(negedge clk);

      // WIDTH=8 instance
      issue8(3'd1, 8'h80, 8'h80);
      wait_done8(cyc);
      check("latency8", cyc, 9);
      check("w8_mult_hi", hi8, 64'h40);
      check("w8_mult_lo", lo8, 64'h00);
      issue8(3'd3, 8'h81, 8'h02);
      wait_done8(cyc);
      check("w8_div_lo", lo8, 64'hC1);
      check("w8_div_hi", hi8, 64'hFF);
      for (int i = 0; i < 8; i++) begin
         issue8(3'($urandom_range(0, 3)), 8'($urandom), (i == 2) ? 8'd0 : 8'($urandom));
         wait_done8(cyc);
      end

      @(negedge clk);
      check("sb32_empty", q32.size(), 0);
      check("sb8_empty", q8.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
